imem_fetch: RTL and testbench

Clocked, loadable instruction memory with a fetch request/valid handshake, the parametrised successor to the hardcoded combinational instruction ROM. It sits between the multicycle CPU's fetch stage and a program-load port, so test programs are written at run time instead of selected at compile time. It adds configurable depth and width, programmable read latency, byte or word addressing, and fault reporting for misaligned or out-of-range fetches.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_storage.sv | 47 ++++
 rtl/imem_fetch.sv | 91 +++++++++
 tb/tb_imem_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants, state encoding and word-index helper for the
// loadable instruction memory.
package imem_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [63:0] NOP_WORD = 64'd0;

    typedef struct packed {
        logic [31:0] idx;
        logic        fault;
    } widx_t;

    // addr arrives zero-extended to 32 bits, so the range test never wraps
    function automatic widx_t word_index(
        input logic [31:0] addr,
        input bit          byte_addr,
        input int unsigned depth
    );
        widx_t r;
        r.idx   = byte_addr ? (addr >> 2) : addr;
        r.fault = (r.idx >= depth) || (byte_addr && (addr[1:0] != 2'b00));
        return r;
    endfunction

endpackage

// File: rtl/imem_storage.sv
// DEPTH x DATA_W flop array: synchronous write, reset to NOP,
// asynchronous read.
module imem_storage
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [31:0]       wr_ext;
    logic [31:0]       rd_ext;
    logic              wr_ok;

    always_comb begin
        wr_ext = '0;
        wr_ext[ADDR_W-1:0] = wr_addr;
        rd_ext = '0;
        rd_ext[IDX_W-1:0] = rd_idx;
    end

    assign wr_ok = wr_en && (wr_ext < 32'(DEPTH));

    assign rd_data = (rd_ext < 32'(DEPTH)) ? mem[rd_idx]
                                           : NOP_WORD[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD[DATA_W-1:0];
            end
        end else if (wr_ok) begin
            mem[wr_ext[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// Loadable instruction memory with a fetch request/valid handshake,
// programmable read latency and misaligned/out-of-range fault reporting.
module imem_fetch
    import imem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 64,
    parameter int READ_LAT  = 1,
    parameter int BYTE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic              fetch_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    logic [0:0]        state;
    logic [1:0]        cnt;
    logic [31:0]       addr_ext;
    widx_t             hit;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_W-1:0] = fetch_addr;
    end

    assign hit = word_index(addr_ext, BYTE_ADDR != 0, DEPTH);

    imem_storage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_idx  (hit.idx[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    assign fetch_ready = (state == ST_IDLE);

    // read happens before the same-edge write lands, so collisions see old data
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            fetch_fault <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        instr       <= hit.fault ? NOP_WORD[DATA_W-1:0]
                                                 : rd_data;
                        fetch_fault <= hit.fault;
                        cnt         <= LAT_M1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        state       <= ST_IDLE;
                        instr_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench: three imem_fetch instances (word/L1, byte/L3, word/L2)
// share request and load inputs; a reference model predicts every pulse.
module tb_imem_fetch;

    localparam int N     = 3;
    localparam int DEPTH = 64;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic [15:0] fa  [N];
    logic        rdy [N];
    logic        vld [N];
    logic        flt [N];
    logic [31:0] ins [N];

    exp_t        sb[$];
    logic [31:0] mmem [DEPTH];
    int          ready_from [N];
    int          lat   [N];
    int          bmode [N];
    int          edge_n  = 0;
    bit          started = 0;
    int          errors  = 0;
    int          checks  = 0;

    imem_fetch #(.READ_LAT(1), .BYTE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fa[0]),
        .fetch_ready(rdy[0]), .instr_valid(vld[0]), .instr(ins[0]),
        .fetch_fault(flt[0]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data));

    imem_fetch #(.READ_LAT(3), .BYTE_ADDR(1)) u1 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fa[1]),
        .fetch_ready(rdy[1]), .instr_valid(vld[1]), .instr(ins[1]),
        .fetch_fault(flt[1]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data));

    imem_fetch #(.READ_LAT(2), .BYTE_ADDR(0)) u2 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fa[2]),
        .fetch_ready(rdy[2]), .instr_valid(vld[2]), .instr(ins[2]),
        .fetch_fault(flt[2]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d edge%0d: got %h want %h",
                     name, i, edge_n, act, exp);
        end
    endtask

    // reference model: a fetch is taken when requested and the unit has been
    // idle since before this edge; the result is due READ_LAT edges later
    initial begin
        lat   = '{1, 3, 2};
        bmode = '{0, 1, 0};
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                for (int w = 0; w < DEPTH; w++) mmem[w] = 32'd0;
                sb.delete();
                for (int i = 0; i < N; i++) ready_from[i] = edge_n;
                started = 1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (fetch_req && (edge_n - 1 >= ready_from[i])) begin
                        exp_t e;
                        int   a;
                        int   w;
                        a = int'(fa[i]);
                        w = bmode[i] != 0 ? a / 4 : a;
                        e.inst  = i;
                        e.due   = edge_n + lat[i];
                        e.fault = (w >= DEPTH) ||
                                  (bmode[i] != 0 && (a % 4) != 0);
                        e.data  = e.fault ? 32'd0 : mmem[w];
                        sb.push_back(e);
                        ready_from[i] = edge_n + lat[i];
                    end
                end
                if (ld_en && int'(ld_addr) < DEPTH) mmem[ld_addr] = ld_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = -1;
                    for (int k = 0; k < sb.size(); k++) begin
                        if (j < 0 && sb[k].inst == i) j = k;
                    end
                    chk("ready", i, 32'(rdy[i]),
                        32'(edge_n >= ready_from[i]));
                    if (vld[i]) begin
                        checks++;
                        if (j < 0 || sb[j].due != edge_n) begin
                            errors++;
                            $display("FAIL valid_unexpected inst%0d edge%0d: got 1 want 0",
                                     i, edge_n);
                        end else begin
                            chk("instr", i, ins[i], sb[j].data);
                            chk("fault", i, 32'(flt[i]), 32'(sb[j].fault));
                            sb.delete(j);
                        end
                    end else if (j >= 0 && sb[j].due <= edge_n) begin
                        checks++;
                        errors++;
                        $display("FAIL valid_missing inst%0d edge%0d: got 0 want 1",
                                 i, edge_n);
                        sb.delete(j);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        fetch_req = 1'b0;
        ld_en     = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int w, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = 16'(w);
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic set_addr(input int w, input int off);
        for (int i = 0; i < N; i++) begin
            fa[i] = bmode[i] != 0 ? 16'(w * 4 + off) : 16'(w);
        end
    endtask

    task automatic fetch(input int w, input int off, input bit wl,
                         input int lw, input logic [31:0] ld);
        idle(5);
        set_addr(w, off);
        fetch_req = 1'b1;
        if (wl) begin
            ld_en   = 1'b1;
            ld_addr = 16'(lw);
            ld_data = ld;
        end
        @(negedge clk);
        fetch_req = 1'b0;
        ld_en     = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        fetch_req = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        for (int i = 0; i < N; i++) fa[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_valid", i, 32'(vld[i]), 32'd0);
            chk("rst_instr", i, ins[i], 32'd0);
            chk("rst_fault", i, 32'(flt[i]), 32'd0);
            chk("rst_ready", i, 32'(rdy[i]), 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        load(1, 32'hC8210005);
        fetch(1, 0, 0, 0, 0);
        fetch(2, 0, 0, 0, 0);
        load(3, 32'h04000000);
        fetch(3, 0, 0, 0, 0);
        fetch(3, 1, 0, 0, 0);
        fetch(64, 0, 0, 0, 0);
        load(64, 32'hDEADBEEF);
        for (int w = 0; w < 6; w++) fetch(w, 0, 0, 0, 0);
        fetch(63, 0, 0, 0, 0);

        load(5, 32'h0000AAAA);
        fetch(5, 0, 1, 5, 32'h00005555);
        fetch(5, 0, 0, 0, 0);

        idle(5);
        fetch_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            set_addr($urandom_range(0, 8), 0);
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_addr = 16'($urandom_range(0, 8));
            ld_data = $urandom;
            @(negedge clk);
        end
        idle(5);

        fetch_req = 1'b1;
        set_addr(1, 0);
        @(negedge clk);
        fetch_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fetch(1, 0, 0, 0, 0);

        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            fetch_req = ($urandom_range(0, 9) < 7);
            set_addr($urandom_range(0, 70),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            ld_en   = ($urandom_range(0, 9) < 3);
            ld_addr = 16'($urandom_range(0, 70));
            ld_data = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        idle(10);
        #1;
        chk("drain", 0, 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
